// File: rtl/mpsoc_apb_gpio_irq.sv
// APB GPIO slave with per-pin direction, atomic set/clear of the outputs, an input synchroniser,
// and per-pin level/edge interrupt detection that feeds a sticky W1C status register and one irq line.
module mpsoc_apb_gpio_irq #(
    parameter int PADDR_SIZE = 10,
    parameter int PDATA_SIZE = 8,
    parameter int SYNC_DEPTH = 3
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [PDATA_SIZE-1:0]   gpio_i,
    output logic [PDATA_SIZE-1:0]   gpio_o,
    output logic [PDATA_SIZE-1:0]   gpio_oe,
    output logic                    irq_o
);

    localparam int NBYTES = PDATA_SIZE / 8;

    localparam logic [3:0] OFF_DIR      = 4'd0;
    localparam logic [3:0] OFF_OUT      = 4'd1;
    localparam logic [3:0] OFF_IN       = 4'd2;
    localparam logic [3:0] OFF_IRQ_EN   = 4'd3;
    localparam logic [3:0] OFF_IRQ_TYPE = 4'd4;
    localparam logic [3:0] OFF_IRQ_POL  = 4'd5;
    localparam logic [3:0] OFF_IRQ_BOTH = 4'd6;
    localparam logic [3:0] OFF_STAT     = 4'd7;
    localparam logic [3:0] OFF_OUT_SET  = 4'd8;
    localparam logic [3:0] OFF_OUT_CLR  = 4'd9;

    // Expand the byte strobes into a per-bit write mask.
    function automatic logic [PDATA_SIZE-1:0] strb_mask(input logic [NBYTES-1:0] strb);
        logic [PDATA_SIZE-1:0] m;
        m = '0;
        for (int b = 0; b < NBYTES; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    // Replace only the strobed byte lanes of a register.
    function automatic logic [PDATA_SIZE-1:0] lane_merge(
        input logic [PDATA_SIZE-1:0] cur,
        input logic [PDATA_SIZE-1:0] wdata,
        input logic [PDATA_SIZE-1:0] mask
    );
        return (cur & ~mask) | (wdata & mask);
    endfunction

    logic [PDATA_SIZE-1:0] dir_r;
    logic [PDATA_SIZE-1:0] out_r;
    logic [PDATA_SIZE-1:0] en_r;
    logic [PDATA_SIZE-1:0] type_r;
    logic [PDATA_SIZE-1:0] pol_r;
    logic [PDATA_SIZE-1:0] both_r;
    logic [PDATA_SIZE-1:0] stat_r;
    logic [PDATA_SIZE-1:0] prev_r;
    logic [PDATA_SIZE-1:0] sync_r [SYNC_DEPTH];
    logic                  irq_r;

    logic [3:0]            offset_s;
    logic                  addr_ok_s;
    logic                  wr_en_s;
    logic [PDATA_SIZE-1:0] mask_s;
    logic [PDATA_SIZE-1:0] wbits_s;
    logic [PDATA_SIZE-1:0] sync_s;
    logic [PDATA_SIZE-1:0] det_s;
    logic [PDATA_SIZE-1:0] stat_clr_s;
    logic [PDATA_SIZE-1:0] stat_next_s;

    // Only PADDR[5:2] is decoded; upper address bits alias.
    generate
        if (PADDR_SIZE > 6) begin : g_addr_hi
            logic unused_addr_hi_s;
            assign unused_addr_hi_s = ^PADDR[PADDR_SIZE-1:6];
        end
    endgenerate

    assign offset_s  = PADDR[5:2];
    assign addr_ok_s = (offset_s <= OFF_OUT_CLR) && (PADDR[1:0] == 2'b00);
    assign wr_en_s   = PSEL & PENABLE & PWRITE & addr_ok_s;
    assign mask_s    = strb_mask(PSTRB);
    assign wbits_s   = PWDATA & mask_s;
    assign sync_s    = sync_r[SYNC_DEPTH-1];

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & ~addr_ok_s;
    assign gpio_o  = out_r;
    assign gpio_oe = dir_r;
    assign irq_o   = irq_r;

    // Per-pin detection: level compares against POL, edge mode uses the sync/prev pair.
    always_comb begin
        det_s = '0;
        for (int i = 0; i < PDATA_SIZE; i++) begin
            if (type_r[i]) begin
                if (both_r[i]) begin
                    det_s[i] = sync_s[i] ^ prev_r[i];
                end else if (pol_r[i]) begin
                    det_s[i] = sync_s[i] & ~prev_r[i];
                end else begin
                    det_s[i] = ~sync_s[i] & prev_r[i];
                end
            end else begin
                det_s[i] = ~(sync_s[i] ^ pol_r[i]);
            end
        end
    end

    // Status update: W1C clear first, then new events OR in so a coincident set wins.
    always_comb begin
        stat_clr_s = '0;
        if (wr_en_s && (offset_s == OFF_STAT)) begin
            stat_clr_s = wbits_s;
        end else begin
            stat_clr_s = '0;
        end
        stat_next_s = (stat_r & ~stat_clr_s) | (det_s & en_r);
    end

    // Read mux, combinational while selected; unmapped or misaligned addresses read zero.
    always_comb begin
        PRDATA = '0;
        if (PSEL && addr_ok_s) begin
            case (offset_s)
                OFF_DIR:      PRDATA = dir_r;
                OFF_OUT:      PRDATA = out_r;
                OFF_IN:       PRDATA = sync_s;
                OFF_IRQ_EN:   PRDATA = en_r;
                OFF_IRQ_TYPE: PRDATA = type_r;
                OFF_IRQ_POL:  PRDATA = pol_r;
                OFF_IRQ_BOTH: PRDATA = both_r;
                OFF_STAT:     PRDATA = stat_r;
                default:      PRDATA = '0;
            endcase
        end else begin
            PRDATA = '0;
        end
    end

    // Input synchroniser chain plus one-cycle history of its last stage.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int k = 0; k < SYNC_DEPTH; k++) begin
                sync_r[k] <= '0;
            end
            prev_r <= '0;
        end else begin
            sync_r[0] <= gpio_i;
            for (int k = 1; k < SYNC_DEPTH; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            prev_r <= sync_s;
        end
    end

    // Register file writes, sticky status and the registered interrupt line.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            dir_r  <= '0;
            out_r  <= '0;
            en_r   <= '0;
            type_r <= '0;
            pol_r  <= '0;
            both_r <= '0;
            stat_r <= '0;
            irq_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                case (offset_s)
                    OFF_DIR:      dir_r  <= lane_merge(dir_r,  PWDATA, mask_s);
                    OFF_OUT:      out_r  <= lane_merge(out_r,  PWDATA, mask_s);
                    OFF_IRQ_EN:   en_r   <= lane_merge(en_r,   PWDATA, mask_s);
                    OFF_IRQ_TYPE: type_r <= lane_merge(type_r, PWDATA, mask_s);
                    OFF_IRQ_POL:  pol_r  <= lane_merge(pol_r,  PWDATA, mask_s);
                    OFF_IRQ_BOTH: both_r <= lane_merge(both_r, PWDATA, mask_s);
                    OFF_OUT_SET:  out_r  <= out_r | wbits_s;
                    OFF_OUT_CLR:  out_r  <= out_r & ~wbits_s;
                    default:      ;
                endcase
            end
            stat_r <= stat_next_s;
            irq_r  <= |(stat_r & en_r);
        end
    end

endmodule

// File: doc/mpsoc_apb_gpio_irq.md
Name: mpsoc_apb_gpio_irq

Overview:
Next-generation APB GPIO slave: PDATA_SIZE pins with per-pin direction, atomic set/clear of outputs, a parametrised input synchroniser, and per-pin interrupt detection. Each pin's interrupt is configurable as level (high/low), single edge (rising/falling) or both edges. A sticky write-1-to-clear status register feeds one registered interrupt line. It sits behind the AHB3/WB-to-APB peripheral bridges, in place of the plain APB GPIO.

Parameters:
PADDR_SIZE, 10, APB address width; must be >= 6, decode uses PADDR[5:2].
PDATA_SIZE, 8, APB data width and GPIO pin count; multiple of 8.
SYNC_DEPTH, 3, input synchroniser flop stages; must be >= 2.

Ports:
PCLK  in  1  clock, all logic rising-edge.
PRESET  in  1  asynchronous, active-high reset.
PSEL  in  1  APB select.
PENABLE  in  1  APB access phase.
PWRITE  in  1  1=write, 0=read.
PSTRB  in  PDATA_SIZE/8  write byte strobes.
PADDR  in  PADDR_SIZE  byte address.
PWDATA  in  PDATA_SIZE  write data.
PRDATA  out  PDATA_SIZE  read data.
PREADY  out  1  always 1, zero wait states.
PSLVERR  out  1  error response.
gpio_i  in  PDATA_SIZE  asynchronous pin inputs.
gpio_o  out  PDATA_SIZE  pin output values (OUT register).
gpio_oe  out  PDATA_SIZE  pin output enables (DIR register).
irq_o  out  1  registered interrupt, high when any (STAT & IRQ_EN) bit is set.

Behaviour:
- Register map, offset = PADDR[5:2]*4:
  - 0x00 DIR: rw.
  - 0x04 OUT: rw.
  - 0x08 IN: ro, synchronised inputs.
  - 0x0C IRQ_EN: rw.
  - 0x10 IRQ_TYPE: rw, 0=level, 1=edge.
  - 0x14 IRQ_POL: rw. Level mode: 1=high-active, 0=low-active. Edge mode: 1=rising, 0=falling.
  - 0x18 IRQ_BOTH: rw. Edge mode only: 1=both edges, overrides POL.
  - 0x1C STAT: W1C.
  - 0x20 OUT_SET: wo, 1 bits set OUT.
  - 0x24 OUT_CLR: wo, 1 bits clear OUT.
- Reset values:
  - All registers, sync chain, edge-history register, irq_o = 0.
  - gpio_o = 0, gpio_oe = 0, PRDATA = 0, PSLVERR = 0, PREADY = 1.
- Write: commits on the PCLK edge where PSEL & PENABLE & PWRITE. Visible the following cycle. Only byte lanes with PSTRB set are affected.
- Writes to IN are ignored, with no error.
- Read: PRDATA is combinational during PSEL. It returns the addressed register. IRQ_BOTH reads its value. OUT_SET and OUT_CLR read 0. PRDATA = 0 when PSEL = 0.
- PSLVERR = PSEL & PENABLE & (offset > 0x24 or PADDR[1:0] != 0). Such accesses have no side effects and read 0.
- Simultaneous OUT_SET/OUT_CLR cannot occur (one access per cycle).
- Synchroniser: SYNC_DEPTH flops per pin; last stage = s. prev = s delayed by 1 cycle.
- Detection per pin i, combinational from s and prev:
  - level: s[i] == POL[i]
  - edge rising: s[i] & ~prev[i]
  - edge falling: ~s[i] & prev[i]
  - both: s[i] ^ prev[i]
- STAT[i] sets on the next edge when detection[i] & IRQ_EN[i]. Disabled pins never set STAT.
- STAT[i] clears on a W1C write of 1. If set and clear occur in the same cycle, set wins.
- Level mode: clearing while the level is still active re-sets STAT the next cycle.
- Clearing IRQ_EN does not clear STAT, but masks its contribution to irq_o.
- irq_o: registered, |(STAT & IRQ_EN).
- Latency, for a pin change stable before clock edge 1:
  - IN reads the new value after edge SYNC_DEPTH.
  - STAT is set after edge SYNC_DEPTH+1.
  - irq_o is high after edge SYNC_DEPTH+2.
- Reset mid-transfer: all state returns to reset values immediately. The transfer is abandoned and no partial write is retained.

Test Plan:
- Reset, then read every offset 0x00–0x24 -> all 0, PSLVERR=0. Read 0x28 -> PSLVERR=1, PRDATA=0.
- Write DIR=0xF0, OUT=0x5A; OUT_SET 0x01; OUT_CLR 0x40 -> gpio_oe=0xF0, gpio_o=0x1B, read OUT=0x1B.
- gpio_i 0x00->0x04, SYNC_DEPTH=3 -> IN=0x04 after 3 edges. With IRQ_EN=0x04, TYPE=0x04, POL=0x04: STAT=0x04 after 4 edges, irq_o=1 after 5. W1C 0x04 -> STAT=0, irq_o=0 next cycle.
- Level high on pin 1 (EN/POL=0x02, TYPE=0): hold gpio_i[1]=1, W1C 0x02 -> STAT re-asserts next cycle. Drop pin and clear -> stays 0.
- IRQ_BOTH=0x01, edge mode on pin 0: toggle 0->1->0, clearing between edges -> STAT[0] sets twice. Pin activity with IRQ_EN=0 -> STAT unchanged.
- Write with PSTRB=0 on PDATA_SIZE=16 build -> register unchanged. Assert PRESET mid-access -> all outputs 0 and irq_o=0 asynchronously.
